// File: rtl/half_dense_layer.sv
`default_nettype none
// ============================================================================
// Module   : half_dense_layer
// Purpose  : Time-multiplexed binary16 fully-connected layer,
//            l = act(x*W + b), LANES neurons processed per group.
//            Per group: LOAD (bias), IN_N MAC cycles, WRITE (activation).
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start         - request, accepted only while idle
//            act_sel       - 0/3 identity, 1 sigmoid, 2 ReLU (sampled w/ start)
//            x [IN_N]      - input vector, captured on accepted start
//            W [IN_N][OUT_N], b [OUT_N] - held stable while busy
//            busy, done    - status; done is a one-cycle pulse
//            l [OUT_N]     - registered result vector
// Packing  : x[i] = x[16*i +: 16], b[j]/l[j] likewise,
//            W[i][j] = W[16*(i*OUT_N+j) +: 16]
// Revision : 1.0 - initial release
// ============================================================================
module half_dense_layer #(
    parameter int IN_N  = 10,
    parameter int OUT_N = 10,
    parameter int LANES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  act_sel,
    input  logic [16*IN_N-1:0]          x,
    input  logic [16*IN_N*OUT_N-1:0]    W,
    input  logic [16*OUT_N-1:0]         b,
    output logic                        busy,
    output logic                        done,
    output logic [16*OUT_N-1:0]         l
);

    localparam int G  = OUT_N / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (OUT_N % LANES != 0) begin : g_bad_lanes
        $error("half_dense_layer: OUT_N must be a multiple of LANES");
    end

    // ------------------------------------------------------------------
    // binary16 arithmetic (round-to-nearest-even, subnormals supported)
    // ------------------------------------------------------------------
    // Rounds the exact value m * 2^e to binary16. The LSB weight of the
    // result is 2^(msb+e-10), floored at 2^-24 for the subnormal range.
    // Adding the rounded significand onto (lsb exponent + 24) << 10 lets a
    // rounding carry ripple naturally into the exponent field.
    function automatic logic [15:0] f16_pack(input logic s, input int e, input logic [39:0] m);
        int          msb, lsb_e, sh, pk;
        logic [39:0] q, rem, hlf;
        msb = -1;
        for (int n = 0; n < 40; n++) if (m[n]) msb = n;
        if (msb < 0) return {s, 15'h0000};
        lsb_e = msb + e - 10;
        if (lsb_e < -24) lsb_e = -24;
        sh = lsb_e - e;
        if (sh <= 0) begin
            q = m << (-sh);
        end else begin
            q   = m >> sh;
            rem = m & ((40'd1 << sh) - 40'd1);
            hlf = 40'd1 << (sh - 1);
            if (rem > hlf || (rem == hlf && q[0])) q = q + 40'd1;
        end
        pk = (lsb_e + 24) * 1024 + int'(q);
        if (pk >= 31744) return {s, 15'h7C00};
        return {s, pk[14:0]};
    endfunction

    function automatic logic [15:0] f16_mul(input logic [15:0] a, input logic [15:0] c);
        logic a_nan, c_nan, a_inf, c_inf, a_zero, c_zero, s;
        int   ea, ec;
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        c_nan  = (c[14:10] == 5'h1F) && (c[9:0] != 10'd0);
        a_inf  = (a[14:0] == 15'h7C00);
        c_inf  = (c[14:0] == 15'h7C00);
        a_zero = (a[14:0] == 15'h0000);
        c_zero = (c[14:0] == 15'h0000);
        s      = a[15] ^ c[15];
        if (a_nan || c_nan || (a_inf && c_zero) || (c_inf && a_zero)) return 16'h7E00;
        if (a_inf || c_inf) return {s, 15'h7C00};
        ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        ec = (c[14:10] == 5'd0) ? 1 : int'(c[14:10]);
        return f16_pack(s, ea + ec - 50,
                        {29'd0, (a[14:10] != 5'd0), a[9:0]} * {29'd0, (c[14:10] != 5'd0), c[9:0]});
    endfunction

    // Both significands are aligned to the smaller exponent, so the signed
    // sum is exact before the single rounding step.
    function automatic logic [15:0] f16_add(input logic [15:0] a, input logic [15:0] c);
        logic        a_nan, c_nan, a_inf, c_inf, s;
        int          ea, ec, emin;
        logic [39:0] ma, mc, m;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        c_nan = (c[14:10] == 5'h1F) && (c[9:0] != 10'd0);
        a_inf = (a[14:0] == 15'h7C00);
        c_inf = (c[14:0] == 15'h7C00);
        if (a_nan || c_nan || (a_inf && c_inf && (a[15] != c[15]))) return 16'h7E00;
        if (a_inf) return a;
        if (c_inf) return c;
        ea   = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        ec   = (c[14:10] == 5'd0) ? 1 : int'(c[14:10]);
        emin = (ea < ec) ? ea : ec;
        ma   = {29'd0, (a[14:10] != 5'd0), a[9:0]} << (ea - emin);
        mc   = {29'd0, (c[14:10] != 5'd0), c[9:0]} << (ec - emin);
        if (a[15] == c[15]) begin
            m = ma + mc;
            s = a[15];
        end else if (ma >= mc) begin
            m = ma - mc;
            s = a[15];
        end else begin
            m = mc - ma;
            s = c[15];
        end
        // Exact cancellation yields +0 under round-to-nearest.
        if (m == 40'd0 && a[15] != c[15]) s = 1'b0;
        return f16_pack(s, emin - 25, m);
    endfunction

    // Piecewise-linear sigmoid on |a|, mirrored as 1-y for negative inputs.
    function automatic logic [15:0] f16_sigmoid(input logic [15:0] a);
        logic [15:0] mag, y;
        mag = {1'b0, a[14:0]};
        if (a[14:10] == 5'h1F && a[9:0] != 10'd0) return a;
        if (mag < 16'h3C00)      y = f16_add(f16_mul(mag, 16'h3400), 16'h3800); // 0.25|a|+0.5
        else if (mag < 16'h40C0) y = f16_add(f16_mul(mag, 16'h3000), 16'h3900); // 0.125|a|+0.625
        else if (mag < 16'h4500) y = f16_add(f16_mul(mag, 16'h2800), 16'h3AC0); // |a|/32+0.84375
        else                     y = 16'h3C00;
        return a[15] ? f16_add(16'h3C00, {1'b1, y[14:0]}) : y;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]             state_q, state_d;
    logic [GW-1:0]          g_q, g_d;
    logic [IW-1:0]          i_q, i_d;
    logic [1:0]             act_q;
    logic [16*IN_N-1:0]     x_q;
    logic [16*LANES-1:0]    acc_q;
    logic [16*OUT_N-1:0]    l_q;

    logic [15:0]            w_x;
    logic [16*LANES-1:0]    w_bias_all, w_sum_all, w_act_all;

    assign w_x = x_q[int'(i_q)*16 +: 16];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [15:0] w_acc, w_wt, w_act;
        assign w_acc = acc_q[k*16 +: 16];
        assign w_wt  = W[(int'(i_q)*OUT_N + int'(g_q)*LANES + k)*16 +: 16];
        assign w_bias_all[k*16 +: 16] = b[(int'(g_q)*LANES + k)*16 +: 16];
        assign w_sum_all[k*16 +: 16]  = f16_add(w_acc, f16_mul(w_x, w_wt));
        always_comb begin
            case (act_q)
                2'd1:    w_act = f16_sigmoid(w_acc);
                2'd2:    w_act = w_acc[15] ? 16'h0000 : w_acc;
                default: w_act = w_acc;
            endcase
        end
        assign w_act_all[k*16 +: 16] = w_act;
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    g_d     = '0;
                    i_d     = '0;
                end
            end
            S_LOAD:  state_d = S_MAC;
            S_MAC: begin
                if (i_q == IW'(IN_N - 1)) state_d = S_WRITE;
                else                      i_d     = i_q + 1'b1;
            end
            S_WRITE: begin
                if (g_q == GW'(G - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    g_d     = g_q + 1'b1;
                    i_d     = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            i_q     <= '0;
            act_q   <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            i_q     <= i_d;
            if (state_q == S_IDLE && start) begin
                x_q   <= x;
                act_q <= act_sel;
            end
            if (state_q == S_LOAD)     acc_q <= w_bias_all;
            else if (state_q == S_MAC) acc_q <= w_sum_all;
            // Only the current group's neurons are written.
            if (state_q == S_WRITE) begin
                for (int k = 0; k < LANES; k++)
                    l_q[(int'(g_q)*LANES + k)*16 +: 16] <= w_act_all[k*16 +: 16];
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign l    = l_q;

endmodule
`default_nettype wire

// File: tb/tb_half_dense_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_dense_layer
// Purpose  : Scoreboard bench for half_dense_layer. Two instances
//            (LANES=1 and LANES=2, IN_N=OUT_N=4) share the stimulus; the
//            expected vector and done cycle are queued per instance and
//            popped by a per-instance monitor whenever done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_dense_layer;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int T1 = 4 * (NI + 2) + 1;   // LANES=1: G=4
    localparam int T2 = 2 * (NI + 2) + 1;   // LANES=2: G=2

    logic               clk = 1'b0;
    logic               rst, start;
    logic [1:0]         act_sel;
    logic [16*NI-1:0]   x;
    logic [16*NI*NO-1:0] W;
    logic [16*NO-1:0]   b;
    logic               d1_busy, d1_done, d2_busy, d2_done;
    logic [16*NO-1:0]   d1_l, d2_l;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] l;
        int          cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    half_dense_layer #(.IN_N(NI), .OUT_N(NO), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .act_sel(act_sel), .x(x), .W(W), .b(b),
        .busy(d1_busy), .done(d1_done), .l(d1_l));

    half_dense_layer #(.IN_N(NI), .OUT_N(NO), .LANES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .act_sel(act_sel), .x(x), .W(W), .b(b),
        .busy(d2_busy), .done(d2_done), .l(d2_l));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int n);
        real p = 1.0;
        if (n >= 0) for (int k = 0; k < n; k++) p = p * 2.0;
        else        for (int k = 0; k < -n; k++) p = p / 2.0;
        return p;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
        else                  v = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    // Nearest binary16 to r, ties to even (finite inputs only).
    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  v, w, q, fl;
        int   e, lsb, pk;
        s = (r < 0.0) || (r == 0.0 && (1.0 / r) < 0.0);
        v = s ? -r : r;
        if (v == 0.0) return {s, 15'd0};
        e = 0;
        w = 1.0;
        while (v >= 2.0 * w) begin w = w * 2.0; e++; end
        while (v < w)        begin w = w / 2.0; e--; end
        lsb = (e - 10 < -24) ? -24 : e - 10;
        q   = v / pow2(lsb);
        fl  = $floor(q);
        if ((q - fl > 0.5) || ((q - fl == 0.5) && (int'(fl) % 2 == 1))) fl = fl + 1.0;
        pk = (lsb + 24) * 1024 + int'(fl);
        if (pk >= 31744) return {s, 15'h7C00};
        return {s, pk[14:0]};
    endfunction

    function automatic logic [63:0] model(input logic [1:0] a, input logic [63:0] xv,
                                          input logic [255:0] wv, input logic [63:0] bv);
        logic [63:0] r;
        logic [15:0] acc, p;
        for (int j = 0; j < NO; j++) begin
            acc = bv[j*16 +: 16];
            for (int i = 0; i < NI; i++) begin
                p   = r2h(h2r(xv[i*16 +: 16]) * h2r(wv[(i*NO+j)*16 +: 16]));
                acc = r2h(h2r(acc) + h2r(p));
            end
            case (a)
                2'd1:    acc = r2h(1.0 / (1.0 + $exp(-h2r(acc))));
                2'd2:    if (acc[15]) acc = 16'h0000;
                default: ;
            endcase
            r[j*16 +: 16] = acc;
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd_h();
        logic [15:0] h;
        h        = 16'($urandom);
        h[14:10] = 5'($urandom_range(0, 20));
        if ($urandom_range(0, 9) == 0) h[14:0] = 15'd0;
        return h;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && d1_done) begin
            if (q1.size() == 0) begin
                chk("d1 spurious done", 128'(d1_done), 128'(0));
            end else begin
                e1 = q1.pop_front();
                chk("d1 l", 128'(d1_l), 128'(e1.l));
                chk("d1 done cycle", 128'(cyc), 128'(e1.cyc));
                chk("d1 busy at done", 128'(d1_busy), 128'(1));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d2_done) begin
            if (q2.size() == 0) begin
                chk("d2 spurious done", 128'(d2_done), 128'(0));
            end else begin
                e2 = q2.pop_front();
                chk("d2 l", 128'(d2_l), 128'(e2.l));
                chk("d2 done cycle", 128'(cyc), 128'(e2.cyc));
                chk("d2 busy at done", 128'(d2_busy), 128'(1));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [63:0] el, input int c1, input int c2, input bit use1);
        exp_t e;
        e.l = el;
        if (use1) begin e.cyc = c1; q1.push_back(e); end
        e.cyc = c2;
        q2.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!d1_busy && !d2_busy && q1.size() == 0 && q2.size() == 0) break;
        end
        chk("drained", {94'd0, d1_busy, d2_busy, 16'(q1.size()), 16'(q2.size())}, 128'd0);
    endtask

    // Issue one start. chain: hold start so LANES=2 restarts at T2+1.
    // restart5: pulse start again at cycle 5 (must be ignored).
    // scramble: change x/act_sel right after the start cycle.
    task automatic run(input logic [1:0] a, input logic [63:0] xv, input logic [255:0] wv,
                       input logic [63:0] bv, input bit chain, input bit restart5, input bit scramble);
        logic [63:0] el;
        int          s;
        el = model(a, xv, wv, bv);
        @(negedge clk);
        x = xv; W = wv; b = bv; act_sel = a; start = 1'b1;
        s = cyc;
        push(el, s + T1, s + T2, 1'b1);
        if (chain) push(el, 0, s + 2*T2 + 1, 1'b0);
        @(negedge clk);
        chk("busy after start", {126'd0, d1_busy, d2_busy}, 128'd3);
        if (!chain) start = 1'b0;
        if (scramble) begin
            for (int i = 0; i < NI; i++) x[i*16 +: 16] = rnd_h();
            act_sel = 2'($urandom_range(0, 3));
        end
        if (chain) begin
            repeat (T2 + 1) @(negedge clk);
            start = 1'b0;
        end
        if (restart5) begin
            repeat (4) @(negedge clk);
            x = ~xv; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain();
    endtask

    logic [63:0]  xv, bv;
    logic [255:0] wv;
    logic [1:0]   a;

    initial begin
        rst = 1'b1; start = 1'b0; act_sel = 2'd0; x = '0; W = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            repeat (3) @(negedge clk);
            chk("idle d1", {62'd0, d1_busy, d1_done, d1_l}, 128'd0);
            chk("idle d2", {62'd0, d2_busy, d2_done, d2_l}, 128'd0);
        end

        // identity: x=1.0, W=0.5, b=0 -> 2.0
        run(2'd0, {4{16'h3C00}}, {16{16'h3800}}, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("identity literal d1", 128'(d1_l), 128'({4{16'h4000}}));
        // ReLU with mixed biases
        run(2'd2, {4{16'h3C00}}, {16{16'h3800}}, {16'h3C00, 16'hC400, 16'h3C00, 16'hC400},
            1'b0, 1'b0, 1'b1);
        chk("relu literal d2", 128'(d2_l), 128'({16'h4200, 16'h0000, 16'h4200, 16'h0000}));
        // sigmoid(0) with an ignored second start at cycle 5
        run(2'd1, {4{16'h4400}}, 256'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("sigmoid literal d1", 128'(d1_l), 128'({4{16'h3800}}));
        // sigmoid saturates high for a large positive input
        run(2'd1, {4{16'h3C00}}, 256'd0, {4{16'h4A00}}, 1'b0, 1'b0, 1'b1);

        // back-to-back chaining with start held high
        for (int i = 0; i < NI; i++) xv[i*16 +: 16] = rnd_h();
        for (int i = 0; i < NI*NO; i++) wv[i*16 +: 16] = rnd_h();
        for (int j = 0; j < NO; j++) bv[j*16 +: 16] = rnd_h();
        run(2'd0, xv, wv, bv, 1'b1, 1'b0, 1'b0);

        // abort: reset at cycle 8 of a run
        @(negedge clk);
        x = ~xv; act_sel = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q1.delete();
        q2.delete();
        chk("abort d1", {63'd0, d1_busy, d1_l}, 128'd0);
        chk("abort d2", {63'd0, d2_busy, d2_l}, 128'd0);
        repeat (30) @(negedge clk);
        run(2'd0, xv, wv, bv, 1'b0, 1'b0, 1'b1);

        // randomized runs
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < NI; i++) xv[i*16 +: 16] = rnd_h();
            for (int i = 0; i < NI*NO; i++) wv[i*16 +: 16] = rnd_h();
            for (int j = 0; j < NO; j++) bv[j*16 +: 16] = rnd_h();
            case ($urandom_range(0, 2))
                0:       a = 2'd0;
                1:       a = 2'd2;
                default: a = 2'd3;
            endcase
            run(a, xv, wv, bv, 1'b0, 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/half_dense_layer.md
# half_dense_layer

Time-multiplexed half-precision (IEEE 754 binary16) fully-connected layer computing l = act(x·W + b) with LANES output neurons processed in parallel per group. It is the parametrised successor to the fixed dot/add/sigmoid layer chain, adding lane-count scaling, a runtime-selectable activation (identity, sigmoid, ReLU), input capture and a busy/done handshake. It sits between layer input buffers and the next layer's start, so layers can be chained done→start.

## Interface
- IN_N, default 10: input vector length, ≥1.
- OUT_N, default 10: output neuron count, ≥1.
- LANES, default 1: parallel MAC lanes. OUT_N % LANES must be 0, otherwise elaboration fails via `$error`.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request. Accepted only in IDLE.
- act_sel  in  2  activation select: 0 identity, 1 sigmoid, 2 ReLU, 3 identity. Sampled with start.
- x  in  16×IN_N  input vector. Captured on accepted start.
- W  in  16×IN_N×OUT_N  weights W[i][j]. Must be held stable while busy.
- b  in  16×OUT_N  biases. Must be held stable while busy.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when all of l is valid.
- l  out  16×OUT_N  result vector. Registered, and held until overwritten.

## Operation
- G = OUT_N/LANES groups. Group g covers neurons j = g·LANES + k for k = 0..LANES-1.
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
  - IDLE: when start=1, capture x and act_sel, clear group counter g and input counter i, then go to LOAD.
  - LOAD (1 cycle): acc[k] ← b[g·LANES+k].
  - MAC (IN_N cycles): acc[k] ← half_add(acc[k], half_mul(x_cap[i], W[i][g·LANES+k])), then i++. Exit after i = IN_N-1.
  - WRITE (1 cycle): l[g·LANES+k] ← act(acc[k]). Then, if g = G-1, go to DONE; otherwise g++, i ← 0, go to LOAD.
  - DONE (1 cycle): done=1, then return to IDLE.
- Arithmetic:
  - half_mul and half_add are the team's combinational binary16 cores (round-to-nearest-even).
  - Each product is rounded to 16 bits before it is added. Accumulation order is strictly bias first, then i ascending.
  - NaN and Inf propagate as the cores produce them.
- Activations:
  - identity passes acc unchanged.
  - ReLU outputs 0x0000 when the sign bit is 1 (including -0 and negative NaN); otherwise it passes acc.
  - sigmoid uses the team's combinational binary16 sigmoid function.
- Only neurons of the current group are written in WRITE. Other l entries keep their previous values.
- start while busy is ignored: no queueing, no restart.
- Counter widths are $clog2 of the range, minimum 1 bit.

## Timing
- Reset (rst=1 at a clock edge): state ← IDLE, busy=0, done=0, all l ← 0x0000, acc, counters and x_cap ← 0.
  - Reset mid-operation aborts the operation. No done pulse is generated.
- Accepted start at edge/cycle 0:
  - busy=1 from cycle 1.
  - Group g's LOAD is at cycle 1+g·(IN_N+2), and its WRITE is at cycle (g+1)·(IN_N+2).
  - done=1 during cycle T = G·(IN_N+2)+1, with busy still 1 in that cycle.
  - busy=0 at T+1, and a new start is accepted at T+1.
- Back-to-back chaining: start held high continuously restarts at T+1, giving throughput of one vector per T+1 cycles.
- x and act_sel may change freely after the start cycle.

## Test plan
- Reset then idle:
  - Stimulus: rst for 2 cycles, start=0.
  - Required: l all 0x0000, busy=0, done=0 indefinitely.
- IN_N=4, OUT_N=4, LANES=1, identity:
  - Stimulus: x all 0x3C00, W all 0x3800, b all 0x0000.
  - Required: done at cycle 4·6+1 = 25, and every l = 0x4000.
- Same setup, LANES=2, ReLU, b = {0xC400, 0x3C00, 0xC400, 0x3C00}:
  - Required: done at cycle 2·6+1 = 13, and l = {0x0000, 0x4200, 0x0000, 0x4200}.
- Sigmoid, W all 0x0000, b all 0x0000:
  - Required: every l = 0x3800.
  - A second start asserted at cycle 5 is ignored, so exactly one done pulse occurs.
- Abort:
  - Stimulus: rst asserted at cycle 8 of a run.
  - Required: l cleared to 0x0000, no done pulse. A fresh start afterwards completes with correct values and done at the nominal cycle.
- Input capture:
  - Stimulus: change x on the cycle after start.
  - Required: results reflect the x captured at start.
